// File: rtl/mcp_send_fifo.sv
// Send-side FIFO that queues producer words for an MCP sender.
// Head word is presented on adatain/asend; a transfer happens when asend & aready.
module mcp_send_fifo #(
  parameter int DATA_LEN = 40,
  parameter int DEPTH    = 8
) (
  input  logic                     aclk,
  input  logic                     arst,
  input  logic                     wr_en,
  input  logic [DATA_LEN-1:0]      wr_data,
  input  logic                     clr_ovf,
  input  logic                     aready,
  output logic                     asend,
  output logic [DATA_LEN-1:0]      adatain,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_LEN-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                pop;
  logic                push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign asend   = !empty;
  assign adatain = mem[rd_ptr];
  assign pop     = asend & aready;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign push    = wr_en & (!full | pop);

  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      // A new overflow event takes priority over a clear on the same edge.
      if (wr_en && full && !pop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule
